// File: rtl/dec_imm_ctrl.sv
// Decode front end: classifies the opcode, registers it with pc and one-hot immediate type, expands the immediate.
// Latency: an instruction accepted on edge N drives dec_* from edge N; throughput 1/cycle with dec_ready high.
// Backpressure: a 2-entry out/skid pair keeps if_ready a flop output; dec_* hold steady while dec_valid & ~dec_ready.
// Build option: define KRV_ZIMM_EN to give csrr*i instructions type 0 with dec_imm = zero-extended rs1 field (zimm).

// Immediate expander for RV32I.
// Latency: purely combinational, no state.
// Backpressure: none; the caller holds instr/type stable.
module imm_gen (
    input  logic [31:7] instr,
    input  logic [4:0]  imm_type,
    output logic [31:0] imm
);

    // One-hot {I,S,B,J,U} selects the bit scramble; no type yields zero.
    always_comb begin
        imm = '0;
        case (imm_type)
            5'b10000: imm = {{20{instr[31]}}, instr[31:20]};
            5'b01000: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            5'b00100: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
            5'b00010: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
            5'b00001: imm = {instr[31:12], 12'b0};
            default:  imm = '0;
        endcase
    end

endmodule

// Decode-stage sequencer between IF and EX around imm_gen.
// Latency: 1 edge from accept to dec_* presentation.
// Backpressure: second entry parks in the skid register and drops if_ready until EX drains.
module dec_imm_ctrl #(
    parameter int DATA_WIDTH = 32,  // only 32 is supported
    parameter int PC_WIDTH   = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  flush,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [DATA_WIDTH-1:0] if_instr,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [PC_WIDTH-1:0]   dec_pc,
    output logic [DATA_WIDTH-1:0] dec_imm,
    output logic [4:0]            dec_imm_type,
    output logic                  dec_illegal
);

    // One queued instruction as it travels through the skid and out registers.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]   pc;
    } entry_t;

    // Decode results captured alongside the instruction in the out register.
    typedef struct packed {
        logic [4:0] imm_type;  // one-hot {I,S,B,J,U}
        logic       illegal;
    } meta_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // nothing held
        ST_HOLD  = 2'd1,  // out register valid, skid free
        ST_FULL  = 2'd2   // out register and skid both valid
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [4:0] IMM_I    = 5'b10000;
    localparam logic [4:0] IMM_S    = 5'b01000;
    localparam logic [4:0] IMM_B    = 5'b00100;
    localparam logic [4:0] IMM_J    = 5'b00010;
    localparam logic [4:0] IMM_U    = 5'b00001;
    localparam logic [4:0] IMM_NONE = 5'b00000;

    // Opcode to immediate type; anything outside the RV32I base map is illegal.
    function automatic meta_t classify(input logic [6:0] opcode);
        meta_t m;
        m.imm_type = IMM_NONE;
        m.illegal  = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC:                              m.imm_type = IMM_U;
            OP_JAL:                                        m.imm_type = IMM_J;
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: m.imm_type = IMM_I;
            OP_STORE:                                      m.imm_type = IMM_S;
            OP_BRANCH:                                     m.imm_type = IMM_B;
            OP_REG:                                        m.imm_type = IMM_NONE;
            default:                                       m.illegal  = 1'b1;
        endcase
        return m;
    endfunction

    state_t                state;
    entry_t                out_ent;
    meta_t                 out_meta;
    entry_t                skid_ent;
    entry_t                load_ent;
    meta_t                 load_meta;
    logic [DATA_WIDTH-1:0] gen_imm;
    logic                  accept;
    logic                  xfer;
`ifdef KRV_ZIMM_EN
    logic                  load_zimm;
    logic                  out_zimm;
`endif

    assign accept = if_valid & if_ready;
    assign xfer   = dec_valid & dec_ready;

    // Out register reloads from the skid when draining FULL, otherwise from IF.
    always_comb begin
        load_ent  = (state == ST_FULL) ? skid_ent : entry_t'{instr: if_instr, pc: if_pc};
        load_meta = classify(load_ent.instr[6:0]);
`ifdef KRV_ZIMM_EN
        // csrr*i carries its operand in the rs1 field instead of an I immediate.
        load_zimm = (load_ent.instr[6:0] == OP_SYSTEM) && load_ent.instr[14];
        if (load_zimm) begin
            load_meta.imm_type = IMM_NONE;
        end
`endif
    end

    // Handshake FSM: flush beats everything; data registers only move on a load.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state     <= ST_EMPTY;
            dec_valid <= 1'b0;
            if_ready  <= 1'b1;
            out_ent   <= '0;
            out_meta  <= '0;
            skid_ent  <= '0;
`ifdef KRV_ZIMM_EN
            out_zimm  <= 1'b0;
`endif
        end else if (flush) begin
            state     <= ST_EMPTY;
            dec_valid <= 1'b0;
            if_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_HOLD;
                        dec_valid <= 1'b1;
                        out_ent   <= load_ent;
                        out_meta  <= load_meta;
`ifdef KRV_ZIMM_EN
                        out_zimm  <= load_zimm;
`endif
                    end
                end
                ST_HOLD: begin
                    if (accept && xfer) begin
                        out_ent  <= load_ent;
                        out_meta <= load_meta;
`ifdef KRV_ZIMM_EN
                        out_zimm <= load_zimm;
`endif
                    end else if (accept) begin
                        // EX stalled: park the newcomer and close the input.
                        state    <= ST_FULL;
                        skid_ent <= load_ent;
                        if_ready <= 1'b0;
                    end else if (xfer) begin
                        state     <= ST_EMPTY;
                        dec_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        state    <= ST_HOLD;
                        if_ready <= 1'b1;
                        out_ent  <= load_ent;
                        out_meta <= load_meta;
`ifdef KRV_ZIMM_EN
                        out_zimm <= load_zimm;
`endif
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    dec_valid <= 1'b0;
                    if_ready  <= 1'b1;
                end
            endcase
        end
    end

    imm_gen u_imm_gen (
        .instr    (out_ent.instr[DATA_WIDTH-1:7]),
        .imm_type (out_meta.imm_type),
        .imm      (gen_imm)
    );

`ifdef KRV_ZIMM_EN
    assign dec_imm = out_zimm ? {{(DATA_WIDTH-5){1'b0}}, out_ent.instr[19:15]} : gen_imm;
`else
    assign dec_imm = gen_imm;
`endif

    assign dec_instr    = out_ent.instr;
    assign dec_pc       = out_ent.pc;
    assign dec_imm_type = out_meta.imm_type;
    assign dec_illegal  = out_meta.illegal;

endmodule
